bldc_count_sampler: RTL and testbench

- Sits directly downstream of the BLDC motor block and consumes its free-running encoder count, hall count and connected flag.
- Every SAMPLE_PERIOD clocks it snapshots both counts and computes wrap-safe signed deltas (ticks per period) for the velocity loop and SPI readout.
- Deltas are delivered through a valid/ready holding register.
- Also owns the motor-side fault latch (prolonged hall disconnect) and sequences counter-clear requests back into the motor block.

---
 rtl/bldc_count_sampler_pkg.sv | 20 ++
 rtl/bldc_sample_timer.sv | 28 ++
 rtl/bldc_count_sampler.sv | 114 +++++++++++
 tb/tb_bldc_count_sampler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bldc_count_sampler_pkg.sv
// bldc_count_sampler_pkg: shared state encoding, timing constants and counter sizing
package bldc_count_sampler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    localparam int CLK_HZ                = 18_432_000;
    localparam int SAMPLE_RATE_HZ        = 1_000;
    localparam int DEFAULT_SAMPLE_PERIOD = CLK_HZ / SAMPLE_RATE_HZ;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bldc_sample_timer.sv
// bldc_sample_timer: free-running 0..PERIOD-1 counter with sync restart/hold and terminal-count tick
module bldc_sample_timer
    import bldc_count_sampler_pkg::*;
#(
    parameter int PERIOD = DEFAULT_SAMPLE_PERIOD
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    input  logic hold,
    output logic tick
);

    localparam int W = cnt_w(PERIOD);
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt;

    assign tick = ~restart & ~hold & (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else
            cnt <= (restart | hold | tick) ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/bldc_count_sampler.sv
// bldc_count_sampler: periodic wrap-safe count deltas with valid/ready holding register,
// hall-disconnect fault latch and counter-clear sequencing for the BLDC motor block.
module bldc_count_sampler
    import bldc_count_sampler_pkg::*;
#(
    parameter int ENCODER_COUNT_WIDTH = 15,
    parameter int HALL_COUNT_WIDTH    = 7,
    parameter int SAMPLE_PERIOD       = DEFAULT_SAMPLE_PERIOD,
    parameter int FAULT_SAMPLES       = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           en,
    input  logic [ENCODER_COUNT_WIDTH-1:0] enc_count,
    input  logic [HALL_COUNT_WIDTH-1:0]    hall_count,
    input  logic                           connected,
    input  logic                           count_clear,
    output logic                           reset_enc_count,
    output logic                           reset_hall_count,
    output logic [ENCODER_COUNT_WIDTH-1:0] enc_delta,
    output logic [HALL_COUNT_WIDTH-1:0]    hall_delta,
    output logic                           sample_valid,
    input  logic                           sample_ready,
    output logic                           overrun,
    input  logic                           overrun_clear,
    output logic                           fault,
    input  logic                           fault_clear,
    output logic                           motor_en
);

    localparam int MW = cnt_w(FAULT_SAMPLES + 1);
    localparam logic [MW-1:0] MISS_MAX = MW'(FAULT_SAMPLES);

    state_t                         state, state_nxt;
    logic                           cc_q;
    logic                           clr_rise;
    logic                           tick;
    logic                           run_tick;
    logic                           prime_tick;
    logic                           set_ovr;
    logic                           set_fault;
    logic [ENCODER_COUNT_WIDTH-1:0] prev_enc;
    logic [HALL_COUNT_WIDTH-1:0]    prev_hall;
    logic [MW-1:0]                  miss;

    assign clr_rise   = count_clear & ~cc_q;
    assign run_tick   = tick & (state == ST_RUN);
    assign prime_tick = tick & (state == ST_PRIME);
    assign set_ovr    = run_tick & sample_valid & ~sample_ready;
    assign set_fault  = run_tick & ~connected & (miss >= MISS_MAX - MW'(1));

    assign reset_enc_count  = (state == ST_CLEAR);
    assign reset_hall_count = (state == ST_CLEAR);

    // Dropping en also holds the timer so a partial period never ticks.
    bldc_sample_timer #(
        .PERIOD (SAMPLE_PERIOD)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (clr_rise),
        .hold    (~en | (state == ST_IDLE) | (state == ST_CLEAR)),
        .tick    (tick)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = en ? ST_PRIME : ST_IDLE;
            ST_PRIME: state_nxt = !en ? ST_IDLE : (tick ? ST_RUN : ST_PRIME);
            ST_RUN:   state_nxt = en ? ST_RUN : ST_IDLE;
            ST_CLEAR: state_nxt = en ? ST_PRIME : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (clr_rise)
            state_nxt = ST_CLEAR;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cc_q         <= 1'b0;
            prev_enc     <= '0;
            prev_hall    <= '0;
            enc_delta    <= '0;
            hall_delta   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            miss         <= '0;
            fault        <= 1'b0;
            motor_en     <= 1'b0;
        end else begin
            state        <= state_nxt;
            cc_q         <= count_clear;
            sample_valid <= run_tick | (sample_valid & ~sample_ready);
            overrun      <= set_ovr | (overrun & ~overrun_clear);
            fault        <= set_fault | (fault & ~fault_clear);
            motor_en     <= en & ~fault;
            miss         <= set_fault   ? MISS_MAX :
                            fault_clear ? '0 :
                            run_tick    ? (connected ? '0 : miss + MW'(1)) : miss;
            if (run_tick | prime_tick) begin
                prev_enc  <= enc_count;
                prev_hall <= hall_count;
            end
            // Modular subtraction yields the two's-complement delta across counter wrap.
            if (run_tick) begin
                enc_delta  <= enc_count - prev_enc;
                hall_delta <= hall_count - prev_hall;
            end
        end
    end

endmodule

// File: tb/tb_bldc_count_sampler.sv
// tb_bldc_count_sampler: randomized and directed checks against a behavioural model of the sampler
module tb_bldc_count_sampler;

    localparam int EW = 15;
    localparam int HW = 7;
    localparam int P  = 8;
    localparam int FS = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic [EW-1:0] enc_count = '0;
    logic [HW-1:0] hall_count = '0;
    logic          connected = 1'b1;
    logic          count_clear = 1'b0;
    logic          reset_enc_count, reset_hall_count;
    logic [EW-1:0] enc_delta;
    logic [HW-1:0] hall_delta;
    logic          sample_valid;
    logic          sample_ready = 1'b0;
    logic          overrun;
    logic          overrun_clear = 1'b0;
    logic          fault;
    logic          fault_clear = 1'b0;
    logic          motor_en;

    int checks = 0;
    int errors = 0;

    bldc_count_sampler #(
        .ENCODER_COUNT_WIDTH (EW),
        .HALL_COUNT_WIDTH    (HW),
        .SAMPLE_PERIOD       (P),
        .FAULT_SAMPLES       (FS)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .en               (en),
        .enc_count        (enc_count),
        .hall_count       (hall_count),
        .connected        (connected),
        .count_clear      (count_clear),
        .reset_enc_count  (reset_enc_count),
        .reset_hall_count (reset_hall_count),
        .enc_delta        (enc_delta),
        .hall_delta       (hall_delta),
        .sample_valid     (sample_valid),
        .sample_ready     (sample_ready),
        .overrun          (overrun),
        .overrun_clear    (overrun_clear),
        .fault            (fault),
        .fault_clear      (fault_clear),
        .motor_en         (motor_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Signed difference of two W-bit counter readings, folded into [-2^(W-1), 2^(W-1)).
    function automatic int wrap(input int d, input int w);
        int m;
        m = 1 << w;
        d = ((d % m) + m) % m;
        return (d >= m / 2) ? d - m : d;
    endfunction

    // Behavioural model: phase 0 waiting, 1 priming, 2 sampling, 3 clearing.
    int m_phase, m_pos, m_prev_e, m_prev_h, m_ed, m_hd, m_miss;
    bit m_v, m_ov, m_flt, m_men, m_pulse, m_cc_last;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_phase = 0; m_pos = 0; m_prev_e = 0; m_prev_h = 0; m_ed = 0; m_hd = 0; m_miss = 0;
            m_v = 0; m_ov = 0; m_flt = 0; m_men = 0; m_pulse = 0; m_cc_last = 0;
        end else begin
            bit rise, counting, tk, smp, setf;
            rise     = count_clear && !m_cc_last;
            counting = (m_phase == 1 || m_phase == 2) && en && !rise;
            tk       = counting && m_pos == P - 1;
            smp      = tk && m_phase == 2;
            setf     = smp && !connected && m_miss >= FS - 1;
            m_pos    = (counting && !tk) ? m_pos + 1 : 0;
            m_men    = en && !m_flt;
            m_ov     = (smp && m_v && !sample_ready) || (m_ov && !overrun_clear);
            m_v      = smp || (m_v && !sample_ready);
            m_flt    = setf || (m_flt && !fault_clear);
            if (setf) m_miss = FS;
            else if (fault_clear) m_miss = 0;
            else if (smp) m_miss = connected ? 0 : m_miss + 1;
            if (smp) begin
                m_ed = wrap(int'(enc_count) - m_prev_e, EW);
                m_hd = wrap(int'(hall_count) - m_prev_h, HW);
            end
            if (tk) begin
                m_prev_e = int'(enc_count);
                m_prev_h = int'(hall_count);
            end
            if (rise) m_phase = 3;
            else if (m_phase == 1) m_phase = !en ? 0 : (tk ? 2 : 1);
            else if (m_phase == 2) m_phase = en ? 2 : 0;
            else m_phase = en ? 1 : 0;
            m_pulse   = (m_phase == 3);
            m_cc_last = count_clear;
        end
    end

    always @(negedge clk) begin
        check("enc_delta", 32'($signed(enc_delta)), m_ed);
        check("hall_delta", 32'($signed(hall_delta)), m_hd);
        check("sample_valid", 32'(sample_valid), 32'(m_v));
        check("overrun", 32'(overrun), 32'(m_ov));
        check("fault", 32'(fault), 32'(m_flt));
        check("motor_en", 32'(motor_en), 32'(m_men));
        check("reset_enc_count", 32'(reset_enc_count), 32'(m_pulse));
        check("reset_hall_count", 32'(reset_hall_count), 32'(m_pulse));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic hold_counts(input logic [EW-1:0] e, input logic [HW-1:0] h);
        enc_count  = e;
        hall_count = h;
        step(P);
    endtask

    initial begin
        step(3);
        check("reset_valid", 32'(sample_valid), 0);
        check("reset_motor_en", 32'(motor_en), 0);
        reset_n = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step(1);
            enc_count = enc_count + EW'(1);
        end
        check("ramp_delta", 32'($signed(enc_delta)), 8);
        check("ramp_valid", 32'(sample_valid), 1);

        hold_counts(15'h7FFE, 7'h7F);
        hold_counts(15'h0003, 7'h01);
        check("wrap_fwd_enc", 32'($signed(enc_delta)), 5);
        check("wrap_fwd_hall", 32'($signed(hall_delta)), 2);
        hold_counts(15'h7FFE, 7'h7F);
        check("wrap_rev_enc", 32'(enc_delta), 32'h7FFB);
        check("wrap_rev_hall", 32'($signed(hall_delta)), -2);
        check("overrun_set", 32'(overrun), 1);

        overrun_clear = 1'b1;
        step(1);
        overrun_clear = 1'b0;
        begin
            int n;
            n = 0;
            while (m_pos != P - 1 && n < 3 * P) begin
                step(1);
                n++;
            end
            check("tick_wait", 32'(m_pos), P - 1);
        end
        sample_ready = 1'b1;
        step(1);
        check("load_xfer_valid", 32'(sample_valid), 1);
        check("load_xfer_overrun", 32'(overrun), 0);

        connected = 1'b0;
        step(FS * P + 2);
        check("fault_set", 32'(fault), 1);
        check("fault_motor_en", 32'(motor_en), 0);
        connected = 1'b1;
        fault_clear = 1'b1;
        step(1);
        fault_clear = 1'b0;
        step(2);
        check("fault_cleared", 32'(fault), 0);
        check("motor_en_back", 32'(motor_en), 1);

        step(3);
        count_clear = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("clear_pulse", 32'(reset_enc_count), 1);
        @(negedge clk);
        check("clear_pulse_end", 32'(reset_hall_count), 0);
        #2 count_clear = 1'b0;
        step(2 * P + 4);

        sample_ready = 1'b0;
        step(2 * P + 2);
        check("pre_reset_valid", 32'(sample_valid), 1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("async_valid", 32'(sample_valid), 0);
        check("async_delta", 32'(enc_delta), 0);
        check("async_motor_en", 32'(motor_en), 0);
        check("async_overrun", 32'(overrun), 0);
        step(2);
        reset_n = 1'b1;
        step(3 * P);

        for (int i = 0; i < 3000; i++) begin
            step(1);
            en            = ($urandom % 32) != 0;
            sample_ready  = $urandom % 2;
            connected     = ($urandom % 4) != 0;
            overrun_clear = ($urandom % 16) == 0;
            fault_clear   = ($urandom % 64) == 0;
            if (($urandom % 100) == 0) count_clear = ~count_clear;
            enc_count  = ($urandom % 20 == 0) ? EW'($urandom) : enc_count + EW'($urandom_range(0, 6)) - EW'(3);
            hall_count = ($urandom % 20 == 0) ? HW'($urandom) : hall_count + HW'($urandom_range(0, 2)) - HW'(1);
        end

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
